// File: rtl/io_irq_unit.sv
// Responder side of the CPU I/O / interrupt interface: 16 output port registers,
// 16 input ports, return-address latch and a 16-line prioritised interrupt capture.
module io_irq_unit #(
  parameter logic [15:0] VECTOR_BASE = 16'hFFF0,
  parameter bit          SYNC_IRQ    = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   io_addr,
  input  logic         io_addr_read,
  input  logic         io_read,
  input  logic         io_write,
  input  logic         io_push,
  input  logic         io_store_retaddr,
  input  logic         io_push_retaddr,
  input  logic         io_push_ints,
  input  logic         io_push_int_addr,
  output logic         io_interrupt,
  inout  wire  [15:0]  d_bus,
  output wire  [15:0]  a_bus,
  input  logic [255:0] port_in,
  output logic [255:0] port_out,
  output logic [15:0]  port_rd_ack,
  output logic [15:0]  port_wr_stb,
  input  logic [15:0]  irq
);

  logic [15:0][15:0] pin, port_q;
  logic [3:0]  sel, addr_q, idx;
  logic [15:0] s2, prev, edges, pending, clr, in_hold, retaddr, d_val;
  logic        bus_ok, d_en, ints_drv;

  assign pin      = port_in;
  assign port_out = port_q;
  assign sel      = io_addr_read ? io_addr : addr_q;

  generate
    if (SYNC_IRQ) begin : g_sync
      logic [15:0] s1;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1 <= '0;
          s2 <= '0;
        end else begin
          s1 <= irq;
          s2 <= s1;
        end
      end
    end else begin : g_nosync
      assign s2 = irq;
    end
  endgenerate

  assign edges        = s2 & ~prev;
  assign io_interrupt = |pending;

  always_comb begin
    idx = 4'd15;
    for (int k = 15; k >= 0; k--)
      if (pending[k]) idx = 4'(k);
  end

  // Anything the CPU is writing onto d_bus this cycle keeps us off the bus.
  assign bus_ok   = rst_n & ~io_write & ~io_store_retaddr;
  assign d_en     = bus_ok & (io_push_ints | io_push_retaddr | io_push);
  assign ints_drv = bus_ok & io_push_ints;

  always_comb begin
    d_val = in_hold;
    if (io_push_ints)         d_val = pending;
    else if (io_push_retaddr) d_val = retaddr;
  end

  assign d_bus = d_en ? d_val : 'z;
  assign a_bus = (rst_n && io_push_int_addr) ? VECTOR_BASE + {12'd0, idx} : 'z;

  always_comb begin
    clr = '0;
    if (io_push_int_addr && io_interrupt) clr[idx] = 1'b1;
    if (ints_drv) clr = clr | pending;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q      <= '0;
      in_hold     <= '0;
      retaddr     <= '0;
      pending     <= '0;
      addr_q      <= '0;
      prev        <= '0;
      port_rd_ack <= '0;
      port_wr_stb <= '0;
    end else begin
      prev        <= s2;
      port_rd_ack <= '0;
      port_wr_stb <= '0;
      if (io_addr_read) addr_q <= io_addr;
      if (io_read) begin
        in_hold          <= pin[sel];
        port_rd_ack[sel] <= 1'b1;
      end
      if (io_write) begin
        port_q[sel]      <= d_bus;
        port_wr_stb[sel] <= 1'b1;
      end
      if (io_store_retaddr || io_push_int_addr) retaddr <= d_bus;
      // New edges OR in after the clear so a same-cycle set survives.
      pending <= (pending & ~clr) | edges;
    end
  end

endmodule

// File: tb/tb_io_irq_unit.sv
// Scoreboarded random + directed bench for io_irq_unit against a cycle-level
// behavioural model of the port file, return latch and interrupt history.
module tb_io_irq_unit;

  typedef struct packed {
    logic        rst;
    logic [3:0]  addr;
    logic        ar, rd, wr, push, st, pret, pints, pia, ddrv;
    logic [15:0] dval;
    logic [15:0] irq;
  } stim_t;

  typedef struct packed {
    logic [15:0]  d, a;
    logic         intr;
    logic [255:0] pout;
    logic [15:0]  rack, wstb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic [3:0]   io_addr = '0;
  logic         io_addr_read = 0, io_read = 0, io_write = 0, io_push = 0;
  logic         io_store_retaddr = 0, io_push_retaddr = 0, io_push_ints = 0, io_push_int_addr = 0;
  logic         io_interrupt;
  wire  [15:0]  d_bus;
  wire  [15:0]  a_bus;
  logic [255:0] port_in = '0;
  logic [255:0] port_out;
  logic [15:0]  port_rd_ack, port_wr_stb;
  logic [15:0]  irq = '0;
  logic         tb_en = 0;
  logic [15:0]  tb_val = '0;

  assign d_bus = tb_en ? tb_val : 'z;

  io_irq_unit dut (
    .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_addr_read(io_addr_read),
    .io_read(io_read), .io_write(io_write), .io_push(io_push),
    .io_store_retaddr(io_store_retaddr), .io_push_retaddr(io_push_retaddr),
    .io_push_ints(io_push_ints), .io_push_int_addr(io_push_int_addr),
    .io_interrupt(io_interrupt), .d_bus(d_bus), .a_bus(a_bus),
    .port_in(port_in), .port_out(port_out), .port_rd_ack(port_rd_ack),
    .port_wr_stb(port_wr_stb), .irq(irq)
  );

  // Reference model state
  logic [15:0] m_port [16];
  logic [15:0] m_in, m_ret, m_pend, m_rack, m_wstb;
  logic [3:0]  m_addr;
  logic [15:0] h1, h2, h3;   // irq as sampled 1, 2 and 3 edges ago
  logic [15:0] cur_d;
  stim_t       cur;
  exp_t        expq[$];
  int          n_vec = 0, n_bad = 0;
  logic [15:0] irq_lvl = '0;
  logic        rst_lvl = 1'b0;
  bit          done = 0;

  function automatic logic [3:0] lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    return 4'd15;
  endfunction

  function automatic stim_t nop();
    stim_t s = '0;
    s.rst = rst_lvl;
    s.irq = irq_lvl;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_port[i] = '0;
    m_in = '0; m_ret = '0; m_pend = '0; m_rack = '0; m_wstb = '0;
    m_addr = '0; h1 = '0; h2 = '0; h3 = '0;
  endtask

  task automatic model_step();
    logic [3:0]  s;
    logic [15:0] rise, take;
    s    = cur.ar ? cur.addr : m_addr;
    rise = h2 & ~h3;
    take = '0;
    m_rack = '0;
    m_wstb = '0;
    if (cur.ar) m_addr = cur.addr;
    if (cur.rd) begin m_in = port_in[16*s +: 16]; m_rack[s] = 1'b1; end
    if (cur.wr) begin m_port[s] = cur_d; m_wstb[s] = 1'b1; end
    if (cur.st || cur.pia) m_ret = cur_d;
    if (cur.pia && m_pend != 0) take[lowest(m_pend)] = 1'b1;
    if (cur.pints && !cur.wr && !cur.st) take = take | cur_d;
    m_pend = (m_pend & ~take) | rise;
    h3 = h2; h2 = h1; h1 = cur.irq;
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    if (cur.rst) model_step();
    #1;
    rst_n = s.rst; io_addr = s.addr; io_addr_read = s.ar; io_read = s.rd;
    io_write = s.wr; io_push = s.push; io_store_retaddr = s.st;
    io_push_retaddr = s.pret; io_push_ints = s.pints; io_push_int_addr = s.pia;
    tb_en = s.ddrv; tb_val = s.dval; irq = s.irq;
    cur = s;
    if (!s.rst) model_reset();
    if (s.wr || s.st)     e.d = s.ddrv ? s.dval : 'z;
    else if (!s.rst)      e.d = 'z;
    else if (s.pints)     e.d = m_pend;
    else if (s.pret)      e.d = m_ret;
    else if (s.push)      e.d = m_in;
    else                  e.d = s.ddrv ? s.dval : 'z;
    cur_d  = e.d;
    e.a    = (s.rst && s.pia) ? 16'hFFF0 + {12'd0, lowest(m_pend)} : 'z;
    e.intr = (m_pend != 0);
    for (int i = 0; i < 16; i++) e.pout[16*i +: 16] = m_port[i];
    e.rack = m_rack;
    e.wstb = m_wstb;
    expq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; pop and compare.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("d_bus",        {240'd0, d_bus},       {240'd0, e.d});
        chk("a_bus",        {240'd0, a_bus},       {240'd0, e.a});
        chk("io_interrupt", {255'd0, io_interrupt}, {255'd0, e.intr});
        chk("port_out",     port_out,              e.pout);
        chk("port_rd_ack",  {240'd0, port_rd_ack}, {240'd0, e.rack});
        chk("port_wr_stb",  {240'd0, port_wr_stb}, {240'd0, e.wstb});
      end
    end
  end

  initial begin
    stim_t s;
    logic [31:0] r1, r2;
    int op;
    cur = '0;
    model_reset();
    for (int i = 0; i < 16; i++) port_in[16*i +: 16] = 16'h1000 + 16'(i);

    // Reset, then OUT 0xBEEF to port 3
    apply(nop()); apply(nop());
    rst_lvl = 1; apply(nop());
    s = nop(); s.addr = 3; s.ar = 1; s.wr = 1; s.ddrv = 1; s.dval = 16'hBEEF; apply(s);
    apply(nop()); apply(nop());

    // IN from port 5
    port_in[16*5 +: 16] = 16'h1234;
    s = nop(); s.addr = 5; s.ar = 1; s.rd = 1; apply(s);
    s = nop(); s.push = 1; apply(s);
    apply(nop());

    // Interrupt entry with irq 2 and 7, then return
    irq_lvl = 16'h0084;
    repeat (4) apply(nop());
    s = nop(); s.pia = 1; s.st = 1; s.ddrv = 1; s.dval = 16'h0042; apply(s);
    apply(nop());
    s = nop(); s.pret = 1; apply(s);

    // GIN colliding with a fresh irq0 edge
    irq_lvl = 16'h0085; repeat (4) apply(nop());
    irq_lvl = 16'h0084; repeat (3) apply(nop());
    irq_lvl = 16'h0085; apply(nop()); apply(nop());
    s = nop(); s.pints = 1; apply(s);
    apply(nop()); apply(nop());

    // Async reset between IN read and push
    s = nop(); s.addr = 9; s.ar = 1; s.rd = 1; apply(s);
    rst_lvl = 0; s = nop(); s.push = 1; apply(s);
    rst_lvl = 1; irq_lvl = '0; apply(nop());
    s = nop(); s.push = 1; apply(s);

    // Randomised traffic
    for (int c = 0; c < 2500; c++) begin
      r1 = $urandom; r2 = $urandom;
      if (r1[31:24] == 0) rst_lvl = 0;
      else if (!rst_lvl && r1[0]) rst_lvl = 1;
      if (r1[23:21] == 0) begin
        logic [31:0] t;
        t = $urandom & $urandom & $urandom;
        irq_lvl = irq_lvl ^ t[15:0];
      end
      for (int i = 0; i < 16; i++) if (r2[i]) port_in[16*i +: 16] = 16'($urandom);
      s = nop();
      s.addr = r1[4:1]; s.ar = r1[5]; s.dval = r2[31:16];
      op = $urandom_range(0, 10);
      case (op)
        2:  begin s.wr = 1; s.ddrv = 1; end
        3:  s.rd = 1;
        4:  s.push = 1;
        5:  s.pret = 1;
        6:  s.pints = 1;
        7:  begin s.pia = 1; s.st = 1; s.ddrv = 1; end
        8:  begin s.st = 1; s.ddrv = 1; end
        9:  begin s.pints = r1[6]; s.pret = r1[7]; s.push = 1; end
        10: begin s.wr = 1; s.ddrv = 1; s.push = 1; s.pints = r1[6]; end
        default: ;
      endcase
      apply(s);
    end

    apply(nop());
    @(negedge clk); @(negedge clk);
    chk("scoreboard_drained", 256'(expq.size()), 256'd0);
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
